// File: rtl/alu_controller.sv
// alu_controller: decodes the MIPS opcode/func fields into a 4-bit ALU operation
// code and flags encodings outside the supported instruction subset.
// With REGISTER_OUTPUT=1 the decode is registered (one cycle of latency) and
// reset forces NOP; with REGISTER_OUTPUT=0 the outputs follow the inputs directly.
module alu_controller #(
  parameter int unsigned REGISTER_OUTPUT = 1
) (
  output logic [3:0] alu_operation,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       clk,
  input  logic       reset,
  output logic       illegal
);

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_AND    = 4'h2,
    OP_OR     = 4'h3,
    OP_XOR    = 4'h4,
    OP_NOR    = 4'h5,
    OP_SLT    = 4'h6,
    OP_SLTU   = 4'h7,
    OP_SLL    = 4'h8,
    OP_SRL    = 4'h9,
    OP_SRA    = 4'hA,
    OP_LUI    = 4'hB,
    OP_MUL    = 4'hC,
    OP_DIV    = 4'hD,
    OP_PASS_B = 4'hE,
    OP_NOP    = 4'hF
  } alu_op_t;

  alu_op_t dec_op;
  logic    dec_illegal;

  // Decode (opcode, func) into an ALU operation; anything unrecognised, including
  // X on the inputs, falls into a default branch that drives NOP and illegal.
  always_comb begin
    dec_op      = OP_NOP;
    dec_illegal = 1'b1;
    case (opcode)
      6'b000000: begin
        dec_illegal = 1'b0;
        case (func)
          6'b100000, 6'b100001: dec_op = OP_ADD;
          6'b100010, 6'b100011: dec_op = OP_SUB;
          6'b100100:            dec_op = OP_AND;
          6'b100101:            dec_op = OP_OR;
          6'b100110:            dec_op = OP_XOR;
          6'b100111:            dec_op = OP_NOR;
          6'b101010:            dec_op = OP_SLT;
          6'b101011:            dec_op = OP_SLTU;
          6'b000000, 6'b000100: dec_op = OP_SLL;
          6'b000010, 6'b000110: dec_op = OP_SRL;
          6'b000011, 6'b000111: dec_op = OP_SRA;
          6'b011000, 6'b011001: dec_op = OP_MUL;
          6'b011010, 6'b011011: dec_op = OP_DIV;
          6'b001000:            dec_op = OP_ADD;
          6'b001100:            dec_op = OP_NOP;
          default: begin
            dec_op      = OP_NOP;
            dec_illegal = 1'b1;
          end
        endcase
      end
      6'b001000, 6'b001001: begin
        dec_op      = OP_ADD;
        dec_illegal = 1'b0;
      end
      6'b001010: begin
        dec_op      = OP_SLT;
        dec_illegal = 1'b0;
      end
      6'b001011: begin
        dec_op      = OP_SLTU;
        dec_illegal = 1'b0;
      end
      6'b001100: begin
        dec_op      = OP_AND;
        dec_illegal = 1'b0;
      end
      6'b001101: begin
        dec_op      = OP_OR;
        dec_illegal = 1'b0;
      end
      6'b001110: begin
        dec_op      = OP_XOR;
        dec_illegal = 1'b0;
      end
      6'b001111: begin
        dec_op      = OP_LUI;
        dec_illegal = 1'b0;
      end
      6'b100000, 6'b100011, 6'b101000, 6'b101011: begin
        dec_op      = OP_ADD;
        dec_illegal = 1'b0;
      end
      6'b000100, 6'b000101: begin
        dec_op      = OP_SUB;
        dec_illegal = 1'b0;
      end
      6'b000110, 6'b000111: begin
        dec_op      = OP_SLT;
        dec_illegal = 1'b0;
      end
      6'b000010, 6'b000011: begin
        dec_op      = OP_NOP;
        dec_illegal = 1'b0;
      end
      default: begin
        dec_op      = OP_NOP;
        dec_illegal = 1'b1;
      end
    endcase
  end

  generate
    if (REGISTER_OUTPUT != 0) begin : g_registered
      // Capture the decode every edge; reset forces a harmless NOP that is not illegal.
      always_ff @(posedge clk) begin
        if (reset) begin
          alu_operation <= OP_NOP;
          illegal       <= 1'b0;
        end else begin
          alu_operation <= dec_op;
          illegal       <= dec_illegal;
        end
      end
    end else begin : g_combinational
      assign alu_operation = dec_op;
      assign illegal       = dec_illegal;
    end
  endgenerate

endmodule

// File: tb/tb_alu_controller.sv
// tb_alu_controller: drives a registered and a combinational alu_controller with
// the same inputs and checks both against a table-driven golden decode.
module tb_alu_controller;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] func;
  logic [3:0] alu_operation;
  logic       illegal;
  logic [3:0] alu_operation_comb;
  logic       illegal_comb;

  int checks;
  int errors;

  // Golden tables indexed by func (R-type) and opcode (everything else); each
  // entry is {illegal, alu_op}. Filled from the instruction list at start-up.
  logic [4:0] rtab[64];
  logic [4:0] itab[64];

  alu_controller #(.REGISTER_OUTPUT(1)) dut (
    .alu_operation(alu_operation),
    .opcode(opcode),
    .func(func),
    .clk(clk),
    .reset(reset),
    .illegal(illegal)
  );

  alu_controller #(.REGISTER_OUTPUT(0)) dut_comb (
    .alu_operation(alu_operation_comb),
    .opcode(opcode),
    .func(func),
    .clk(clk),
    .reset(reset),
    .illegal(illegal_comb)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] golden(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'd0) return rtab[fn];
    return itab[op];
  endfunction

  task automatic checkOutput(input string tag, input logic [4:0] observed, input logic [4:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got illegal=%b op=%h, expected illegal=%b op=%h",
               tag, observed[4], observed[3:0], expected[4], expected[3:0]);
    end
  endtask

  // Drive one instruction on the falling edge, check the combinational instance
  // straight away and the registered instance just after the next rising edge.
  task automatic applyStimulus(input string tag, input logic [5:0] op, input logic [5:0] fn);
    logic [4:0] exp;
    exp = golden(op, fn);
    @(negedge clk);
    opcode = op;
    func   = fn;
    #1;
    checkOutput({tag, "_comb"}, {illegal_comb, alu_operation_comb}, exp);
    @(posedge clk);
    #1;
    checkOutput({tag, "_reg"}, {illegal, alu_operation}, exp);
  endtask

  task automatic setR(input logic [5:0] fn, input logic [3:0] aop);
    rtab[fn] = {1'b0, aop};
  endtask

  task automatic setI(input logic [5:0] op, input logic [3:0] aop);
    itab[op] = {1'b0, aop};
  endtask

  initial begin
    logic [5:0] rop;
    logic [5:0] rfn;
    checks = 0;
    errors = 0;

    for (int i = 0; i < 64; i++) begin
      rtab[i] = 5'h1F;
      itab[i] = 5'h1F;
    end
    setR(6'b100000, 4'h0); setR(6'b100001, 4'h0);
    setR(6'b100010, 4'h1); setR(6'b100011, 4'h1);
    setR(6'b100100, 4'h2); setR(6'b100101, 4'h3);
    setR(6'b100110, 4'h4); setR(6'b100111, 4'h5);
    setR(6'b101010, 4'h6); setR(6'b101011, 4'h7);
    setR(6'b000000, 4'h8); setR(6'b000100, 4'h8);
    setR(6'b000010, 4'h9); setR(6'b000110, 4'h9);
    setR(6'b000011, 4'hA); setR(6'b000111, 4'hA);
    setR(6'b011000, 4'hC); setR(6'b011001, 4'hC);
    setR(6'b011010, 4'hD); setR(6'b011011, 4'hD);
    setR(6'b001000, 4'h0); setR(6'b001100, 4'hF);
    setI(6'b001000, 4'h0); setI(6'b001001, 4'h0);
    setI(6'b001010, 4'h6); setI(6'b001011, 4'h7);
    setI(6'b001100, 4'h2); setI(6'b001101, 4'h3);
    setI(6'b001110, 4'h4); setI(6'b001111, 4'hB);
    setI(6'b100000, 4'h0); setI(6'b100011, 4'h0);
    setI(6'b101000, 4'h0); setI(6'b101011, 4'h0);
    setI(6'b000100, 4'h1); setI(6'b000101, 4'h1);
    setI(6'b000110, 4'h6); setI(6'b000111, 4'h6);
    setI(6'b000010, 4'hF); setI(6'b000011, 4'hF);

    // Reset held for two edges with a legal ADDIU on the inputs.
    reset  = 1'b1;
    opcode = 6'b001001;
    func   = 6'b000000;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      checkOutput("reset_hold", {illegal, alu_operation}, 5'h0F);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("first_after_reset", {illegal, alu_operation}, 5'h00);

    // Directed cases.
    applyStimulus("add",     6'b000000, 6'b100000);
    applyStimulus("sub",     6'b000000, 6'b100010);
    applyStimulus("addiu",   6'b001001, 6'h3F);
    applyStimulus("beq",     6'b000100, 6'b000000);
    applyStimulus("lui",     6'b001111, 6'b010101);
    applyStimulus("sw",      6'b101011, 6'b111000);
    applyStimulus("syscall", 6'b000000, 6'b001100);
    applyStimulus("bad_fn",  6'b000000, 6'b111111);
    applyStimulus("jal",     6'b000011, 6'b000000);
    applyStimulus("bad_op",  6'b111111, 6'b100000);

    // Reset mid-stream overrides the decode of that cycle.
    @(negedge clk);
    reset  = 1'b1;
    opcode = 6'b111111;
    func   = 6'b000000;
    @(posedge clk);
    #1;
    checkOutput("reset_mid", {illegal, alu_operation}, 5'h0F);
    checkOutput("reset_mid_comb", {illegal_comb, alu_operation_comb}, 5'h1F);
    @(negedge clk);
    reset = 1'b0;

    // Full sweeps, new input every cycle.
    for (int i = 0; i < 64; i++) applyStimulus("sweep_op", 6'(i), 6'b100000);
    for (int i = 0; i < 64; i++) applyStimulus("sweep_fn", 6'b000000, 6'(i));

    // Random instructions, half of them R-type.
    for (int i = 0; i < 300; i++) begin
      rop = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
      rfn = 6'($urandom_range(0, 63));
      applyStimulus("random", rop, rfn);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
